hood_mode_ctrl: RTL and testbench

//  Top-level range-hood mode scheduler: decodes debounced key pulses, sets fan level, runs hurricane
//  (level-3) timing, and sequences the self-clean unit (start pulse out, done pulse in, abort on power-off).

---
 rtl/hood_mode_ctrl_if.sv | 26 ++
 rtl/hood_mode_ctrl.sv | 128 ++++++++++++
 tb/tb_hood_mode_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/hood_mode_ctrl_if.sv
// hood_mode_ctrl_if: key/tick/done inputs and fan/clean/status outputs of the hood scheduler
interface hood_mode_ctrl_if #(parameter int WT_W = 17);
    logic            tick_1hz;
    logic            power_key;
    logic            menu_key;
    logic            lvl1_key;
    logic            lvl2_key;
    logic            lvl3_key;
    logic            clean_key;
    logic            clean_done;
    logic [1:0]      fan_level;
    logic            clean_start;
    logic            clean_abort;
    logic [2:0]      state;
    logic [7:0]      remaining;
    logic [WT_W-1:0] work_time;
    logic            remind;
    modport master (
        output tick_1hz, power_key, menu_key, lvl1_key, lvl2_key, lvl3_key, clean_key, clean_done,
        input  fan_level, clean_start, clean_abort, state, remaining, work_time, remind
    );
    modport slave (
        input  tick_1hz, power_key, menu_key, lvl1_key, lvl2_key, lvl3_key, clean_key, clean_done,
        output fan_level, clean_start, clean_abort, state, remaining, work_time, remind
    );
endinterface

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: range-hood mode scheduler (fan level, hurricane timing, self-clean, work time); HOOD_AUTO_OFF_EN adds standby auto-off
module hood_mode_ctrl #(
    parameter int HURRICANE_SEC = 60,
    parameter int RETURN_SEC    = 60,
    parameter int REMIND_SEC    = 36000,
    parameter int WT_W          = 17,
    parameter int IDLE_SEC      = 30
) (
    input logic clk,
    input logic rst,
    hood_mode_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_OFF, S_STANDBY, S_RUN, S_HURR, S_HURR_EXIT, S_CLEAN_REQ, S_CLEAN_WAIT
    } state_t;

    localparam logic [7:0]      HURR_LD  = 8'(HURRICANE_SEC);
    localparam logic [7:0]      RET_LD   = 8'(RETURN_SEC);
    localparam logic [WT_W-1:0] REMIND_V = WT_W'(REMIND_SEC);

    state_t          st, st_nxt;
    logic [1:0]      fan, fan_nxt, lvl_nxt;
    logic [7:0]      rem, rem_nxt;
    logic [WT_W-1:0] wt, wt_nxt;
    logic            hurr_used, cs, ca, remind, idle_exp;
    logic            k_pwr, k_cln, k_l3, k_l2, k_l1, k_menu;

    // only the highest-priority key of a cycle is seen by the FSM
    assign k_pwr  = bus.power_key;
    assign k_cln  = bus.clean_key & ~k_pwr;
    assign k_l3   = bus.lvl3_key & ~k_pwr & ~bus.clean_key;
    assign k_l2   = bus.lvl2_key & ~k_pwr & ~bus.clean_key & ~bus.lvl3_key;
    assign k_l1   = bus.lvl1_key & ~k_pwr & ~bus.clean_key & ~bus.lvl3_key & ~bus.lvl2_key;
    assign k_menu = bus.menu_key & ~k_pwr & ~bus.clean_key & ~bus.lvl3_key & ~bus.lvl2_key & ~bus.lvl1_key;

`ifdef HOOD_AUTO_OFF_EN
    logic [7:0] idle;
    logic       any_key;
    assign any_key  = |{bus.power_key, bus.clean_key, bus.lvl3_key, bus.lvl2_key, bus.lvl1_key, bus.menu_key};
    assign idle_exp = bus.tick_1hz && !any_key && idle == 8'(IDLE_SEC - 1);
    // idle seconds in standby; zero outside standby and whenever a key arrives
    always_ff @(posedge clk)
        idle <= (!rst || st != S_STANDBY || st_nxt != S_STANDBY || any_key) ? 8'd0 : idle + {7'd0, bus.tick_1hz};
`else
    assign idle_exp = 1'b0;
`endif

    // next state, fan level and countdown; countdowns load on the entry cycle
    always_comb begin
        st_nxt  = st;
        lvl_nxt = fan;
        rem_nxt = 8'd0;
        case (st)
            S_OFF: st_nxt = k_pwr ? S_STANDBY : S_OFF;
            S_STANDBY:
                if (k_pwr) st_nxt = S_OFF;
                else if (k_cln) st_nxt = S_CLEAN_REQ;
                else if (k_l3 && !hurr_used) st_nxt = S_HURR;
                else if (k_l2 || k_l1) begin
                    st_nxt  = S_RUN;
                    lvl_nxt = k_l2 ? 2'd2 : 2'd1;
                end
                else if (idle_exp) st_nxt = S_OFF;
            S_RUN:
                if (k_pwr) st_nxt = S_OFF;
                else if (k_l3 && !hurr_used) st_nxt = S_HURR;
                else if (k_l2 || k_l1) lvl_nxt = k_l2 ? 2'd2 : 2'd1;
                else if (k_menu) st_nxt = S_STANDBY;
            S_HURR:
                if (k_pwr) st_nxt = S_OFF;
                else if (k_menu) st_nxt = S_HURR_EXIT;
                else if (bus.tick_1hz && rem == 8'd1) begin
                    st_nxt  = S_RUN;
                    lvl_nxt = 2'd2;
                end
                else rem_nxt = rem - {7'd0, bus.tick_1hz};
            S_HURR_EXIT:
                if (k_pwr) st_nxt = S_OFF;
                else if (bus.tick_1hz && rem == 8'd1) st_nxt = S_STANDBY;
                else rem_nxt = rem - {7'd0, bus.tick_1hz};
            S_CLEAN_REQ: st_nxt = S_CLEAN_WAIT;
            S_CLEAN_WAIT:
                if (k_pwr) st_nxt = S_OFF;
                else if (bus.clean_done) st_nxt = S_STANDBY;
            default: st_nxt = S_OFF;
        endcase
        if (st_nxt == S_HURR && st != S_HURR) rem_nxt = HURR_LD;
        if (st_nxt == S_HURR_EXIT && st != S_HURR_EXIT) rem_nxt = RET_LD;
        fan_nxt = (st_nxt == S_RUN) ? lvl_nxt : (st_nxt == S_HURR || st_nxt == S_HURR_EXIT) ? 2'd3 : 2'd0;
    end

    // work time counts fan-on seconds, saturates, and clears when a self-clean completes
    always_comb begin
        wt_nxt = (st == S_CLEAN_WAIT && !k_pwr && bus.clean_done) ? '0 :
                 (bus.tick_1hz && fan != 2'd0 && wt != '1) ? wt + WT_W'(1) : wt;
    end

    // registered state and outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            st        <= S_OFF;
            fan       <= 2'd0;
            rem       <= 8'd0;
            hurr_used <= 1'b0;
            wt        <= '0;
            remind    <= 1'b0;
            cs        <= 1'b0;
            ca        <= 1'b0;
        end else begin
            st        <= st_nxt;
            fan       <= fan_nxt;
            rem       <= rem_nxt;
            hurr_used <= (st_nxt == S_OFF) ? 1'b0 : (st_nxt == S_HURR) ? 1'b1 : hurr_used;
            wt        <= wt_nxt;
            remind    <= wt_nxt >= REMIND_V;
            cs        <= st_nxt == S_CLEAN_REQ;
            ca        <= st == S_CLEAN_WAIT && k_pwr;
        end
    end

    assign bus.state       = st;
    assign bus.fan_level   = fan;
    assign bus.remaining   = rem;
    assign bus.work_time   = wt;
    assign bus.remind      = remind;
    assign bus.clean_start = cs;
    assign bus.clean_abort = ca;
endmodule

// File: tb/tb_hood_mode_ctrl.sv
// tb_hood_mode_ctrl: directed scenarios plus random key/tick traffic checked against a behavioural model
module tb_hood_mode_ctrl;
    localparam int HS = 5, RS = 3, REM = 10, WTW = 5, IDLE = 4, WT_MAX = 31;
    localparam logic [5:0] N = 6'b000000, P = 6'b100000, C = 6'b010000, L3 = 6'b001000,
                           L2 = 6'b000100, L1 = 6'b000010, M = 6'b000001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   checking = 1'b0;

    int m_st, m_lvl, m_rem, m_hu, m_wt, m_cs, m_ca, m_idle;

    hood_mode_ctrl_if #(.WT_W(WTW)) bus ();

    hood_mode_ctrl #(
        .HURRICANE_SEC(HS), .RETURN_SEC(RS), .REMIND_SEC(REM), .WT_W(WTW), .IDLE_SEC(IDLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic [5:0] k, input logic t = 1'b0, input logic d = 1'b0);
        {bus.power_key, bus.clean_key, bus.lvl3_key, bus.lvl2_key, bus.lvl1_key, bus.menu_key} = k;
        bus.tick_1hz   = t;
        bus.clean_done = d;
        @(posedge clk);
        #1;
        {bus.power_key, bus.clean_key, bus.lvl3_key, bus.lvl2_key, bus.lvl1_key, bus.menu_key} = '0;
        bus.tick_1hz   = 1'b0;
        bus.clean_done = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(N, 1'b1);
    endtask

    function automatic int exp_fan();
        return (m_st == 2) ? m_lvl : (m_st == 3 || m_st == 4) ? 3 : 0;
    endfunction

    // behavioural model: keys resolved by priority, then the mode rules applied per clock
    always @(posedge clk) begin
        int  k, ns;
        bit  kv[6];
        if (!rst) begin
            m_st = 0; m_lvl = 0; m_rem = 0; m_hu = 0; m_wt = 0; m_cs = 0; m_ca = 0; m_idle = 0;
        end else begin
            kv = '{bus.power_key, bus.clean_key, bus.lvl3_key, bus.lvl2_key, bus.lvl1_key, bus.menu_key};
            k = 0;
            for (int i = 5; i >= 0; i--) if (kv[i]) k = i + 1;
            if (bus.tick_1hz && exp_fan() != 0 && m_wt < WT_MAX) m_wt++;
            m_ca = (m_st == 6 && k == 1);
            ns = m_st;
            case (m_st)
                0: if (k == 1) ns = 1;
                1: begin
                    if (k == 1) ns = 0;
                    else if (k == 2) ns = 5;
                    else if (k == 3 && m_hu == 0) ns = 3;
                    else if (k == 4 || k == 5) begin ns = 2; m_lvl = (k == 4) ? 2 : 1; end
`ifdef HOOD_AUTO_OFF_EN
                    if (k != 0) m_idle = 0;
                    else if (bus.tick_1hz) begin
                        m_idle++;
                        if (m_idle == IDLE) ns = 0;
                    end
`endif
                end
                2: begin
                    if (k == 1) ns = 0;
                    else if (k == 3 && m_hu == 0) ns = 3;
                    else if (k == 4 || k == 5) m_lvl = (k == 4) ? 2 : 1;
                    else if (k == 6) ns = 1;
                end
                3: begin
                    if (k == 1) ns = 0;
                    else if (k == 6) ns = 4;
                    else if (bus.tick_1hz) begin
                        if (m_rem == 1) begin ns = 2; m_lvl = 2; end
                        else m_rem--;
                    end
                end
                4: begin
                    if (k == 1) ns = 0;
                    else if (bus.tick_1hz) begin
                        if (m_rem == 1) ns = 1;
                        else m_rem--;
                    end
                end
                5: ns = 6;
                default: begin
                    if (k == 1) ns = 0;
                    else if (bus.clean_done) begin ns = 1; m_wt = 0; end
                end
            endcase
            if (ns == 0) m_hu = 0;
            if (ns == 3 && m_st != 3) begin m_rem = HS; m_hu = 1; end
            if (ns == 4 && m_st != 4) m_rem = RS;
            if (ns != 3 && ns != 4) m_rem = 0;
            if (ns != 1) m_idle = 0;
            m_cs = (ns == 5) ? 1 : 0;
            m_st = ns;
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (checking) begin
            chk("state", int'(bus.state), m_st);
            chk("fan_level", int'(bus.fan_level), exp_fan());
            chk("remaining", int'(bus.remaining), m_rem);
            chk("work_time", int'(bus.work_time), m_wt);
            chk("remind", int'(bus.remind), (m_wt >= REM) ? 1 : 0);
            chk("clean_start", int'(bus.clean_start), m_cs);
            chk("clean_abort", int'(bus.clean_abort), m_ca);
        end
    end

    initial begin
        logic [5:0] kr;
        step(N);
        step(N);
        checking = 1'b1;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_fan", int'(bus.fan_level), 0);
        chk("rst_wt", int'(bus.work_time), 0);
        rst = 1'b1;
        step(P);
        chk("pwr_on", int'(bus.state), 1);
        step(L3);
        chk("hurr_state", int'(bus.state), 3);
        chk("hurr_fan", int'(bus.fan_level), 3);
        chk("hurr_rem", int'(bus.remaining), 5);
        ticks(4);
        chk("hurr_rem1", int'(bus.remaining), 1);
        ticks(1);
        chk("hurr_drop_state", int'(bus.state), 2);
        chk("hurr_drop_fan", int'(bus.fan_level), 2);
        chk("hurr_wt", int'(bus.work_time), 5);
        step(L3);
        chk("hurr_used_state", int'(bus.state), 2);
        step(L1);
        chk("lvl1_fan", int'(bus.fan_level), 1);
        step(L2);
        chk("lvl2_fan", int'(bus.fan_level), 2);
        step(M);
        chk("menu_state", int'(bus.state), 1);
        chk("menu_fan", int'(bus.fan_level), 0);
        step(P);
        step(P);
        step(L3);
        chk("hurr_again", int'(bus.state), 3);
        ticks(2);
        step(M);
        chk("exit_state", int'(bus.state), 4);
        chk("exit_rem", int'(bus.remaining), 3);
        chk("exit_fan", int'(bus.fan_level), 3);
        ticks(2);
        chk("wt9_remind", int'(bus.remind), 0);
        ticks(1);
        chk("exit_done", int'(bus.state), 1);
        chk("wt10", int'(bus.work_time), 10);
        chk("wt10_remind", int'(bus.remind), 1);
        step(C);
        chk("creq_state", int'(bus.state), 5);
        chk("creq_start", int'(bus.clean_start), 1);
        step(N);
        chk("cwait_state", int'(bus.state), 6);
        chk("cwait_start", int'(bus.clean_start), 0);
        step(N, 1'b0, 1'b1);
        chk("cdone_state", int'(bus.state), 1);
        chk("cdone_wt", int'(bus.work_time), 0);
        chk("cdone_remind", int'(bus.remind), 0);
        step(L1);
        ticks(3);
        step(M);
        step(C);
        step(N);
        step(P, 1'b0, 1'b1);
        chk("abort_state", int'(bus.state), 0);
        chk("abort_pulse", int'(bus.clean_abort), 1);
        chk("abort_wt", int'(bus.work_time), 3);
        step(N);
        chk("abort_clear", int'(bus.clean_abort), 0);
        step(P);
        step(L2);
        ticks(6);
        chk("wt9_remind_b", int'(bus.remind), 0);
        ticks(1);
        chk("wt10_remind_b", int'(bus.remind), 1);
        ticks(40);
        chk("wt_sat", int'(bus.work_time), 31);
        step(M);
`ifdef HOOD_AUTO_OFF_EN
        ticks(3);
        chk("idle3", int'(bus.state), 1);
        ticks(1);
        chk("idle_off", int'(bus.state), 0);
`else
        ticks(10);
        chk("no_idle_off", int'(bus.state), 1);
`endif
        for (int n = 0; n < 4000; n++) begin
            kr[5] = ($urandom_range(0, 39) == 0);
            for (int b = 0; b < 5; b++) kr[b] = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 299) != 0);
            step(kr, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
        end
        rst = 1'b1;
        step(N);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
